// File: rtl/bilinear_src_fetcher_if.sv
// Line-store read bus between the bilinear source fetcher (master) and the
// source line store (slave): one request per cycle, quartet returned one cycle later.
interface bilinear_src_fetcher_if #(
  parameter int IMG_W_W = 12
);
  logic               o_rd_en;
  logic [IMG_W_W-1:0] o_rd_row;
  logic [IMG_W_W-1:0] o_rd_col0;
  logic [IMG_W_W-1:0] o_rd_col1;
  logic [7:0]         i_rd_data_00;
  logic [7:0]         i_rd_data_01;
  logic [7:0]         i_rd_data_10;
  logic [7:0]         i_rd_data_11;

  modport master (
    output o_rd_en, o_rd_row, o_rd_col0, o_rd_col1,
    input  i_rd_data_00, i_rd_data_01, i_rd_data_10, i_rd_data_11
  );

  modport slave (
    input  o_rd_en, o_rd_row, o_rd_col0, o_rd_col1,
    output i_rd_data_00, i_rd_data_01, i_rd_data_10, i_rd_data_11
  );
endinterface

// File: rtl/bilinear_src_fetcher.sv
// Walks the destination raster, maps each output pixel to a clamped source quartet,
// fetches it from the line store and feeds pixels plus fractional offsets to the interpolator.
module bilinear_src_fetcher #(
  parameter int SCALE_FW = 8,
  parameter int IMG_W_W  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [IMG_W_W-1:0]    i_src_width,
  input  logic [IMG_W_W-1:0]    i_src_height,
  input  logic [IMG_W_W-1:0]    i_dst_width,
  input  logic [IMG_W_W-1:0]    i_dst_height,
  input  logic [SCALE_FW+3:0]   i_step_x,
  input  logic [SCALE_FW+3:0]   i_step_y,
  input  logic [IMG_W_W-1:0]    i_src_rows_ready,
  bilinear_src_fetcher_if.master rd_if,
  output logic [7:0]            o_pix_data_00,
  output logic [7:0]            o_pix_data_01,
  output logic [7:0]            o_pix_data_10,
  output logic [7:0]            o_pix_data_11,
  output logic [SCALE_FW-1:0]   o_offset_x,
  output logic [SCALE_FW-1:0]   o_offset_y,
  output logic                  o_bi_calc_en,
  output logic                  o_busy,
  output logic                  o_frame_done
);
  localparam int ACC_W = IMG_W_W + SCALE_FW;
  localparam logic [IMG_W_W-1:0] C_ONE = {{(IMG_W_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_ROW = 2'd1,
    S_RUN      = 2'd2,
    S_LINE_END = 2'd3
  } state_t;

  state_t               r_state, w_next_state;
  logic [IMG_W_W-1:0]   r_src_w, r_src_h, r_dst_w, r_dst_h, r_dst_x, r_dst_y;
  logic [SCALE_FW+3:0]  r_step_x, r_step_y;
  logic [ACC_W-1:0]     r_acc_x, r_acc_y;
  logic [IMG_W_W-1:0]   w_x0, w_x1, w_y0, w_y1;
  logic [SCALE_FW-1:0]  w_fx, w_fy, r_fx0, r_fy0, r_fx1, r_fy1;
  logic                 w_accept, w_issue, w_line_end, w_row_ok, w_last_px, w_last_line;
  logic                 r_last0, r_last1, r_v1;

  // Accumulators saturate instead of wrapping so runaway steps stay clamped at the edge.
  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [SCALE_FW+3:0] b);
    logic [ACC_W:0] sum;
    sum = {1'b0, a} + {{(IMG_W_W-3){1'b0}}, b};
    if (sum[ACC_W]) sat_add = {ACC_W{1'b1}};
    else            sat_add = sum[ACC_W-1:0];
  endfunction

  // Source coordinate decode with edge clamping
  always_comb begin
    w_x0 = r_acc_x[ACC_W-1:SCALE_FW];
    w_x1 = w_x0 + C_ONE;
    w_fx = r_acc_x[SCALE_FW-1:0];
    if (r_acc_x[ACC_W-1:SCALE_FW] >= r_src_w - C_ONE) begin
      w_x0 = r_src_w - C_ONE;
      w_x1 = r_src_w - C_ONE;
      w_fx = '0;
    end else begin
      w_fx = r_acc_x[SCALE_FW-1:0];
    end
    w_y0 = r_acc_y[ACC_W-1:SCALE_FW];
    w_y1 = w_y0 + C_ONE;
    w_fy = r_acc_y[SCALE_FW-1:0];
    if (r_acc_y[ACC_W-1:SCALE_FW] >= r_src_h - C_ONE) begin
      w_y0 = r_src_h - C_ONE;
      w_y1 = r_src_h - C_ONE;
      w_fy = '0;
    end else begin
      w_fy = r_acc_y[SCALE_FW-1:0];
    end
  end

  assign w_row_ok    = (i_src_rows_ready > w_y1);
  assign w_last_px   = (r_dst_x == r_dst_w - C_ONE);
  assign w_last_line = (r_dst_y == r_dst_h - C_ONE);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // FSM next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:     if (w_accept)    w_next_state = S_WAIT_ROW; else w_next_state = S_IDLE;
      S_WAIT_ROW: if (w_row_ok)    w_next_state = S_RUN;      else w_next_state = S_WAIT_ROW;
      S_RUN:      if (w_last_px)   w_next_state = S_LINE_END; else w_next_state = S_RUN;
      S_LINE_END: if (w_last_line) w_next_state = S_IDLE;     else w_next_state = S_WAIT_ROW;
      default:    w_next_state = S_IDLE;
    endcase
  end

  // FSM decoded controls; a start is only taken once the previous frame has drained
  always_comb begin
    w_accept   = 1'b0;
    w_issue    = 1'b0;
    w_line_end = 1'b0;
    case (r_state)
      S_IDLE:     w_accept   = i_start & ~o_busy;
      S_RUN:      w_issue    = 1'b1;
      S_LINE_END: w_line_end = 1'b1;
      default:    w_issue    = 1'b0;
    endcase
  end

  // Latched geometry, raster counters and accumulators
  always_ff @(posedge clk) begin
    if (rst) begin
      r_src_w <= '0; r_src_h <= '0; r_dst_w <= '0; r_dst_h <= '0;
      r_step_x <= '0; r_step_y <= '0;
      r_acc_x <= '0; r_acc_y <= '0; r_dst_x <= '0; r_dst_y <= '0;
    end else if (w_accept) begin
      r_src_w <= i_src_width;  r_src_h <= i_src_height;
      r_dst_w <= i_dst_width;  r_dst_h <= i_dst_height;
      r_step_x <= i_step_x;    r_step_y <= i_step_y;
      r_acc_x <= '0; r_acc_y <= '0; r_dst_x <= '0; r_dst_y <= '0;
    end else if (w_issue) begin
      if (w_last_px) begin
        r_acc_x <= '0;
        r_dst_x <= '0;
      end else begin
        r_acc_x <= sat_add(r_acc_x, r_step_x);
        r_dst_x <= r_dst_x + C_ONE;
      end
    end else if (w_line_end && !w_last_line) begin
      r_acc_y <= sat_add(r_acc_y, r_step_y);
      r_dst_y <= r_dst_y + C_ONE;
    end
  end

  // Request stage, read-return stage and interpolator feed stage
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_if.o_rd_en <= 1'b0; rd_if.o_rd_row <= '0; rd_if.o_rd_col0 <= '0; rd_if.o_rd_col1 <= '0;
      r_fx0 <= '0; r_fy0 <= '0; r_fx1 <= '0; r_fy1 <= '0;
      r_last0 <= 1'b0; r_last1 <= 1'b0; r_v1 <= 1'b0;
      o_pix_data_00 <= '0; o_pix_data_01 <= '0; o_pix_data_10 <= '0; o_pix_data_11 <= '0;
      o_offset_x <= '0; o_offset_y <= '0;
      o_bi_calc_en <= 1'b0; o_frame_done <= 1'b0; o_busy <= 1'b0;
    end else begin
      rd_if.o_rd_en <= w_issue;
      r_last0       <= w_issue & w_last_px & w_last_line;
      if (w_issue) begin
        rd_if.o_rd_row  <= w_y0;
        rd_if.o_rd_col0 <= w_x0;
        rd_if.o_rd_col1 <= w_x1;
        r_fx0 <= w_fx;
        r_fy0 <= w_fy;
      end
      r_v1    <= rd_if.o_rd_en;
      r_last1 <= rd_if.o_rd_en & r_last0;
      r_fx1   <= r_fx0;
      r_fy1   <= r_fy0;
      o_bi_calc_en <= r_v1;
      o_frame_done <= r_v1 & r_last1;
      if (r_v1) begin
        o_pix_data_00 <= rd_if.i_rd_data_00;
        o_pix_data_01 <= rd_if.i_rd_data_01;
        o_pix_data_10 <= rd_if.i_rd_data_10;
        o_pix_data_11 <= rd_if.i_rd_data_11;
        o_offset_x    <= r_fx1;
        o_offset_y    <= r_fy1;
      end
      if (w_accept)          o_busy <= 1'b1;
      else if (o_frame_done) o_busy <= 1'b0;
    end
  end
endmodule

// File: tb/tb_bilinear_src_fetcher.sv
// Self-checking bench: RAM model on the read bus plus a per-pixel reference of the
// destination-to-source mapping built with plain arithmetic.
module tb_bilinear_src_fetcher;
  localparam int FW     = 8;
  localparam int WW     = 12;
  localparam int MAXACC = (1 << (WW + FW)) - 1;

  typedef struct {
    int row, c0, c1, fx, fy, d00, d01, d10, d11;
    bit last;
  } exp_t;

  logic clk = 1'b0;
  logic rst, i_start;
  logic [WW-1:0] i_src_width, i_src_height, i_dst_width, i_dst_height, i_src_rows_ready;
  logic [FW+3:0] i_step_x, i_step_y;
  logic [7:0] o_pix_data_00, o_pix_data_01, o_pix_data_10, o_pix_data_11;
  logic [FW-1:0] o_offset_x, o_offset_y;
  logic o_bi_calc_en, o_busy, o_frame_done;

  exp_t req_q[$];
  exp_t out_q[$];
  int   rd_cyc_q[$];
  int   n_checks = 0, n_errors = 0, rd_cnt = 0, done_cnt = 0, done_base = 0, cyc = 0, cur_sh = 1;
  bit   mon_on = 1'b0;

  bilinear_src_fetcher_if #(.IMG_W_W(WW)) rd_if ();

  bilinear_src_fetcher #(.SCALE_FW(FW), .IMG_W_W(WW)) dut (
    .clk(clk), .rst(rst), .i_start(i_start),
    .i_src_width(i_src_width), .i_src_height(i_src_height),
    .i_dst_width(i_dst_width), .i_dst_height(i_dst_height),
    .i_step_x(i_step_x), .i_step_y(i_step_y), .i_src_rows_ready(i_src_rows_ready),
    .rd_if(rd_if),
    .o_pix_data_00(o_pix_data_00), .o_pix_data_01(o_pix_data_01),
    .o_pix_data_10(o_pix_data_10), .o_pix_data_11(o_pix_data_11),
    .o_offset_x(o_offset_x), .o_offset_y(o_offset_y),
    .o_bi_calc_en(o_bi_calc_en), .o_busy(o_busy), .o_frame_done(o_frame_done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int mem_px(input int r, input int c);
    return (r * 29 + c * 7 + r * c + 3) & 255;
  endfunction

  // One axis of the mapping: source position = index * step, saturated, then edge clamp.
  task automatic map_axis(input int d, input int step, input int dim,
                          output int p0, output int p1, output int f);
    longint a;
    a = longint'(d) * longint'(step);
    if (a > MAXACC) a = MAXACC;
    p0 = int'(a >> FW);
    if (p0 >= dim - 1) begin
      p0 = dim - 1; p1 = dim - 1; f = 0;
    end else begin
      p1 = p0 + 1; f = int'(a % (1 << FW));
    end
  endtask

  task automatic build_model(input int sw, input int sh, input int dw, input int dh,
                             input int sx, input int sy);
    exp_t e;
    int x0, x1, fx, y0, y1, fy;
    for (int dy = 0; dy < dh; dy++) begin
      map_axis(dy, sy, sh, y0, y1, fy);
      for (int dx = 0; dx < dw; dx++) begin
        map_axis(dx, sx, sw, x0, x1, fx);
        e.row = y0; e.c0 = x0; e.c1 = x1; e.fx = fx; e.fy = fy;
        e.d00 = mem_px(y0, x0); e.d01 = mem_px(y0, x1);
        e.d10 = mem_px(y1, x0); e.d11 = mem_px(y1, x1);
        e.last = (dy == dh - 1) && (dx == dw - 1);
        req_q.push_back(e);
        out_q.push_back(e);
      end
    end
  endtask

  // Line-store model: quartet registered one cycle after the request
  always @(posedge clk) begin
    if (rd_if.o_rd_en) begin
      int r0, r1;
      r0 = int'(rd_if.o_rd_row);
      r1 = (r0 + 1 < cur_sh) ? r0 + 1 : r0;
      rd_if.i_rd_data_00 <= 8'(mem_px(r0, int'(rd_if.o_rd_col0)));
      rd_if.i_rd_data_01 <= 8'(mem_px(r0, int'(rd_if.o_rd_col1)));
      rd_if.i_rd_data_10 <= 8'(mem_px(r1, int'(rd_if.o_rd_col0)));
      rd_if.i_rd_data_11 <= 8'(mem_px(r1, int'(rd_if.o_rd_col1)));
    end
  end

  // Output monitor against the reference queues
  always @(negedge clk) begin
    exp_t e;
    int c;
    cyc++;
    if (mon_on) begin
      if (rd_if.o_rd_en) begin
        rd_cnt++;
        rd_cyc_q.push_back(cyc);
        if (req_q.size() == 0) check_val("rd_unexpected", 1, 0);
        else begin
          e = req_q.pop_front();
          check_val("rd_row", rd_if.o_rd_row, e.row);
          check_val("rd_col0", rd_if.o_rd_col0, e.c0);
          check_val("rd_col1", rd_if.o_rd_col1, e.c1);
        end
      end
      if (o_bi_calc_en) begin
        if (rd_cyc_q.size() == 0) check_val("calc_without_rd", 1, 0);
        else begin
          c = rd_cyc_q.pop_front();
          check_val("latency", cyc - c, 2);
        end
        if (out_q.size() == 0) check_val("calc_unexpected", 1, 0);
        else begin
          e = out_q.pop_front();
          check_val("pix00", o_pix_data_00, e.d00);
          check_val("pix01", o_pix_data_01, e.d01);
          check_val("pix10", o_pix_data_10, e.d10);
          check_val("pix11", o_pix_data_11, e.d11);
          check_val("offset_x", o_offset_x, e.fx);
          check_val("offset_y", o_offset_y, e.fy);
          check_val("frame_done_align", o_frame_done, e.last);
        end
      end else if (o_frame_done) begin
        check_val("done_without_calc", 1, 0);
      end
      if (o_frame_done) done_cnt++;
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    req_q.delete(); out_q.delete(); rd_cyc_q.delete();
  endtask

  task automatic start_frame(input int sw, input int sh, input int dw, input int dh,
                             input int sx, input int sy, input int rr);
    @(negedge clk);
    i_src_width = WW'(sw); i_src_height = WW'(sh);
    i_dst_width = WW'(dw); i_dst_height = WW'(dh);
    i_step_x = 12'(sx); i_step_y = 12'(sy);
    i_src_rows_ready = WW'(rr);
    cur_sh = sh;
    build_model(sw, sh, dw, dh, sx, sy);
    done_base = done_cnt;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check_val("busy_after_start", o_busy, 1);
  endtask

  task automatic wait_done(input bit extra_start);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      i_start = (extra_start && k == 3);
      if (o_frame_done) begin
        seen = 1'b1;
        break;
      end
    end
    i_start = 1'b0;
    check_val("frame_done_seen", seen, 1);
    if (!seen) apply_reset();
    else begin
      check_val("busy_at_done", o_busy, 1);
      repeat (5) begin
        @(negedge clk);
        check_val("busy_idle", o_busy, 0);
        check_val("no_rd_idle", rd_if.o_rd_en, 0);
      end
      check_val("req_q_empty", req_q.size(), 0);
      check_val("out_q_empty", out_q.size(), 0);
      check_val("done_pulses", done_cnt - done_base, 1);
    end
  endtask

  task automatic run_frame(input int sw, input int sh, input int dw, input int dh,
                           input int sx, input int sy, input int rr, input bit extra_start);
    start_frame(sw, sh, dw, dh, sx, sy, rr);
    wait_done(extra_start);
  endtask

  task automatic row_stall_test();
    bit got;
    start_frame(4, 4, 4, 4, 256, 256, 1);
    repeat (10) @(negedge clk);
    check_val("stall_no_rd", rd_cnt, 0);
    i_src_rows_ready = 12'd2;
    got = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (rd_if.o_rd_en) begin
        got = 1'b1;
        check_val("stall_release_cycles", k <= 2, 1);
        break;
      end
    end
    check_val("stall_release_seen", got, 1);
    repeat (12) @(negedge clk);
    check_val("line1_stalled", rd_cnt, 4);
    i_src_rows_ready = 12'd3;
    repeat (8) @(negedge clk);
    check_val("line1_released", rd_cnt, 8);
    repeat (6) @(negedge clk);
    check_val("line2_stalled", rd_cnt, 8);
    i_src_rows_ready = 12'd4;
    wait_done(1'b0);
  endtask

  task automatic reset_mid_frame_test();
    bit got;
    start_frame(4, 4, 8, 4, 200, 300, 4);
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rd_if.o_rd_en) begin
        got = 1'b1;
        break;
      end
    end
    check_val("mid_rd_seen", got, 1);
    mon_on = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_val("mid_rst_rd_en", rd_if.o_rd_en, 0);
    check_val("mid_rst_calc", o_bi_calc_en, 0);
    check_val("mid_rst_busy", o_busy, 0);
    check_val("mid_rst_done", o_frame_done, 0);
    check_val("mid_rst_pix", {o_pix_data_00, o_pix_data_11, o_offset_x, o_offset_y}, 0);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_val("mid_rst_flush", o_bi_calc_en, 0);
    end
    repeat (4) begin
      @(negedge clk);
      check_val("mid_rst_stays_idle", {o_busy, rd_if.o_rd_en}, 0);
    end
    req_q.delete(); out_q.delete(); rd_cyc_q.delete();
    mon_on = 1'b1;
  endtask

  initial begin
    int sw, sh, dw, dh, sx, sy;
    rst = 1'b1; i_start = 1'b0;
    i_src_width = '0; i_src_height = '0; i_dst_width = '0; i_dst_height = '0;
    i_step_x = '0; i_step_y = '0; i_src_rows_ready = '0;
    repeat (3) @(negedge clk);
    check_val("rst_rd_en", rd_if.o_rd_en, 0);
    check_val("rst_calc", o_bi_calc_en, 0);
    check_val("rst_busy", o_busy, 0);
    check_val("rst_done", o_frame_done, 0);
    check_val("rst_addr", {rd_if.o_rd_row, rd_if.o_rd_col0, rd_if.o_rd_col1}, 0);
    check_val("rst_pix", {o_pix_data_00, o_pix_data_01, o_pix_data_10, o_pix_data_11}, 0);
    check_val("rst_offs", {o_offset_x, o_offset_y}, 0);
    rst = 1'b0;
    mon_on = 1'b1;

    run_frame(4, 2, 4, 2, 256, 256, 2, 1'b1);   // identity, plus an ignored second start
    run_frame(2, 2, 4, 4, 128, 128, 2, 1'b0);   // 2x upscale
    rd_cnt = 0;
    row_stall_test();
    reset_mid_frame_test();
    run_frame(5, 3, 3, 2, 0, 0, 3, 1'b0);       // zero step repeats coordinate
    run_frame(4, 2, 300, 1, 4095, 0, 2, 1'b0);  // accumulator saturates, no wrap
    run_frame(1, 1, 3, 3, 4095, 4095, 1, 1'b0); // single-pixel source

    for (int n = 0; n < 10; n++) begin
      sw = $urandom_range(1, 8);
      sh = $urandom_range(1, 6);
      dw = $urandom_range(1, 10);
      dh = $urandom_range(1, 6);
      sx = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 4095);
      sy = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 4095);
      run_frame(sw, sh, dw, dh, sx, sy, sh, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
